n2nbyn_b2_seq_divider: RTL and testbench

//  Sequential base-2 divider: 2N-digit dividend by N-digit divisor, giving an N-digit quotient and an N-digit remainder.
//  - Restoring algorithm: one quotient digit per clock, MSB first. Parametrised successor of the

---
 rtl/n2nbyn_b2_seq_divider.sv | 101 ++++++++++
 tb/tb_n2nbyn_b2_seq_divider.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/n2nbyn_b2_seq_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock,
// MSB first, with a feasibility check and an soc/eoc handshake.
module n2nbyn_b2_seq_divider #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           soc,
  input  logic [2*N-1:0] x,
  input  logic [N-1:0]   y,
  output logic           eoc,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           no_div
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N-1:0]  x_lo;
  logic [N-1:0]  y_reg;
  logic [N-1:0]  p;
  logic [N-1:0]  quo;
  logic [CW-1:0] cnt;
  logic          inf;

  logic [N:0]    t;
  logic [N:0]    diff;
  logic          qbit;
  logic [N-1:0]  p_next;

  // P < y holds at every step start, so T - y always fits back into N bits.
  always_comb begin
    t      = {p, x_lo[N-1]};
    diff   = t - {1'b0, y_reg};
    qbit   = (t >= {1'b0, y_reg});
    p_next = qbit ? diff[N-1:0] : t[N-1:0];
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state  <= IDLE;
      eoc    <= 1'b1;
      q      <= '0;
      r      <= '0;
      no_div <= 1'b0;
      x_lo   <= '0;
      y_reg  <= '0;
      p      <= '0;
      quo    <= '0;
      cnt    <= '0;
      inf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (soc) begin
            eoc   <= 1'b0;
            y_reg <= y;
            x_lo  <= x[N-1:0];
            quo   <= '0;
            if ((y == '0) || (x[2*N-1:N] >= y)) begin
              inf   <= 1'b1;
              state <= DONE;
            end else begin
              inf   <= 1'b0;
              p     <= x[2*N-1:N];
              cnt   <= CW'(N);
              state <= CALC;
            end
          end
        end
        CALC: begin
          p    <= p_next;
          quo  <= {quo[N-2:0], qbit};
          x_lo <= {x_lo[N-2:0], 1'b0};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          if (!soc) begin
            eoc   <= 1'b1;
            state <= IDLE;
            if (inf) begin
              q      <= '0;
              r      <= '0;
              no_div <= 1'b1;
            end else begin
              q      <= quo;
              r      <= p;
              no_div <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n2nbyn_b2_seq_divider.sv
// Self-checking bench for n2nbyn_b2_seq_divider (N=4): directed table, held-soc,
// reset-abort and an exhaustive feasible sweep against an arithmetic reference.
module tb_n2nbyn_b2_seq_divider;

  localparam int N = 4;

  logic           clock;
  logic           reset_;
  logic           soc;
  logic [2*N-1:0] x;
  logic [N-1:0]   y;
  logic           eoc;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           no_div;

  int checks;
  int errors;

  logic [N-1:0] prev_q, prev_r;
  logic         prev_nd;

  n2nbyn_b2_seq_divider #(.N(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
    .x      (x),
    .y      (y),
    .eoc    (eoc),
    .q      (q),
    .r      (r),
    .no_div (no_div)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] xv;
    logic [3:0] yv;
    logic [3:0] eq;
    logic [3:0] er;
    logic       end_;
    int         lat;
  } vec_t;

  vec_t vecs [0:8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues a one-cycle soc, scrambles x/y after capture, waits for eoc and returns latency.
  task automatic run_op(input logic [7:0] xv, input logic [3:0] yv,
                        output int lat, output logic held_ok);
    @(negedge clock);
    x = xv; y = yv; soc = 1'b1;
    @(posedge clock); #1;
    soc = 1'b0; x = ~xv; y = ~yv;
    held_ok = (eoc == 1'b0) && (q == prev_q) && (r == prev_r) && (no_div == prev_nd);
    lat = 0;
    while (eoc == 1'b0 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (eoc == 1'b0 && (q != prev_q || r != prev_r || no_div != prev_nd)) held_ok = 1'b0;
    end
  endtask

  initial begin
    int   lat;
    logic held_ok;
    int   sweep_bad;

    checks = 0; errors = 0;
    soc = 1'b0; x = '0; y = '0;
    reset_ = 1'b0;
    #12;
    chk("reset_eoc", eoc, 1);
    chk("reset_q", q, 0);
    chk("reset_r", r, 0);
    chk("reset_no_div", no_div, 0);
    reset_ = 1'b1;
    prev_q = '0; prev_r = '0; prev_nd = 1'b0;

    vecs[0] = '{8'h64, 4'h7, 4'hE, 4'h2, 1'b0, 5};
    vecs[1] = '{8'hEF, 4'hF, 4'hF, 4'hE, 1'b0, 5};
    vecs[2] = '{8'h70, 4'h7, 4'h0, 4'h0, 1'b1, 1};
    vecs[3] = '{8'h12, 4'h0, 4'h0, 4'h0, 1'b1, 1};
    vecs[4] = '{8'h09, 4'h3, 4'h3, 4'h0, 1'b0, 5};
    vecs[5] = '{8'h0E, 4'hF, 4'h0, 4'hE, 1'b0, 5};
    vecs[6] = '{8'h7F, 4'h8, 4'hF, 4'h7, 1'b0, 5};
    vecs[7] = '{8'hFF, 4'hF, 4'h0, 4'h0, 1'b1, 1};
    vecs[8] = '{8'h00, 4'h1, 4'h0, 4'h0, 1'b0, 5};

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].xv, vecs[i].yv, lat, held_ok);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_hold", i), held_ok, 1);
      chk($sformatf("vec%0d_q", i), q, vecs[i].eq);
      chk($sformatf("vec%0d_r", i), r, vecs[i].er);
      chk($sformatf("vec%0d_no_div", i), no_div, vecs[i].end_);
      prev_q = vecs[i].eq; prev_r = vecs[i].er; prev_nd = vecs[i].end_;
    end

    // soc held high for 20 cycles: eoc stays low, outputs hold the previous result.
    @(negedge clock);
    x = 8'h64; y = 4'h7; soc = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (eoc != 1'b0 || q != prev_q || r != prev_r || no_div != prev_nd) held_ok = 1'b0;
    end
    chk("soc_held_stable", held_ok, 1);
    @(negedge clock);
    soc = 1'b0;
    chk("soc_held_eoc_low", eoc, 0);
    @(posedge clock); #1;
    chk("soc_held_eoc", eoc, 1);
    chk("soc_held_q", q, 4'hE);
    chk("soc_held_r", r, 4'h2);
    chk("soc_held_no_div", no_div, 0);
    prev_q = 4'hE; prev_r = 4'h2; prev_nd = 1'b0;

    // Reset during the second CALC step aborts without exposing a result.
    @(negedge clock);
    x = 8'hEF; y = 4'hF; soc = 1'b1;
    @(posedge clock); #1;
    soc = 1'b0;
    @(posedge clock); #1;
    reset_ = 1'b0;
    #1;
    chk("abort_eoc", eoc, 1);
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_no_div", no_div, 0);
    @(negedge clock);
    reset_ = 1'b1;
    prev_q = '0; prev_r = '0; prev_nd = 1'b0;
    run_op(8'h09, 4'h3, lat, held_ok);
    chk("after_abort_latency", lat, 5);
    chk("after_abort_q", q, 3);
    chk("after_abort_r", r, 0);
    chk("after_abort_no_div", no_div, 0);
    prev_q = 4'h3; prev_r = 4'h0; prev_nd = 1'b0;

    // Every feasible operand pair, issued back to back.
    sweep_bad = 0;
    for (int yy = 1; yy < 16; yy++) begin
      for (int xx = 0; xx < yy * 16; xx++) begin
        int eqv, erv;
        eqv = xx / yy;
        erv = xx % yy;
        run_op(8'(xx), 4'(yy), lat, held_ok);
        checks++;
        if (lat != 5 || !held_ok || int'(q) != eqv || int'(r) != erv || no_div != 1'b0 ||
            int'(q) * yy + int'(r) != xx || int'(r) >= yy) begin
          errors++;
          sweep_bad++;
          if (sweep_bad <= 10)
            $display("FAIL sweep x=%0d y=%0d: got q=%0d r=%0d no_div=%0d lat=%0d hold=%0d expected q=%0d r=%0d no_div=0 lat=5 hold=1",
                     xx, yy, q, r, no_div, lat, held_ok, eqv, erv);
        end
        prev_q = 4'(eqv); prev_r = 4'(erv); prev_nd = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
